// File: rtl/wm_cycle_timer.sv
// wm_cycle_timer
//   Timing and supervision controller for the washing-machine FSM. It watches
//   the washer's motor_on / drain_on / fill_on, times the wash and spin phases
//   from the selected program, and hands back timeout / spin_timeout. It also
//   runs an independent fill watchdog.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-low reset
//   prog[1:0]    in   program select, sampled only on wash-phase entry
//   pause        in   freezes the phase prescaler and tick counter
//   motor_on     in   washer wash cycle running
//   drain_on     in   washer spin/drain running
//   fill_on      in   washer filling
//   clear_fault  in   clears fill_fault (synchronous)
//   timeout      out  wash phase expired (level)
//   spin_timeout out  spin phase expired (level)
//   fill_fault   out  sticky fill-overrun fault
//   busy         out  FSM not in IDLE
//   phase[2:0]   out  0 IDLE, 1 WASH, 2 WASH_EXP, 3 SPIN, 4 SPIN_EXP
//   remaining    out  ticks left in WASH/SPIN, 0 elsewhere
//
// All outputs are registered. They are decoded from next-state values, so
// they line up with the state register without any input->output path.
module wm_cycle_timer #(
    parameter int PRESCALE      = 1000,
    parameter int CNT_W         = 8,
    parameter int WASH_T_QUICK  = 10,
    parameter int WASH_T_NORMAL = 20,
    parameter int WASH_T_HEAVY  = 40,
    parameter int SPIN_T        = 15,
    parameter int FILL_LIMIT    = 30
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       prog,
    input  logic             pause,
    input  logic             motor_on,
    input  logic             drain_on,
    input  logic             fill_on,
    input  logic             clear_fault,
    output logic             timeout,
    output logic             spin_timeout,
    output logic             fill_fault,
    output logic             busy,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] remaining
);

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    // A zero duration is treated as one tick, and oversize durations are
    // clamped so the tick counter can never start out wrapped.
    function automatic logic [CNT_W-1:0] dur(input int t);
        int max_v;
        max_v = (1 << CNT_W) - 1;
        if (t <= 0)
            return CNT_W'(1);
        else if (t > max_v)
            return CNT_W'(max_v);
        else
            return CNT_W'(t);
    endfunction

    localparam logic [CNT_W-1:0] D_QUICK  = dur(WASH_T_QUICK);
    localparam logic [CNT_W-1:0] D_NORMAL = dur(WASH_T_NORMAL);
    localparam logic [CNT_W-1:0] D_HEAVY  = dur(WASH_T_HEAVY);
    localparam logic [CNT_W-1:0] D_SPIN   = dur(SPIN_T);

    // A fill limit of 0 is treated as 1 tick.
    localparam int FL = (FILL_LIMIT < 1) ? 1 : FILL_LIMIT;
    localparam int FW = $clog2(FL + 1);
    localparam logic [FW-1:0] FL_V   = FW'(FL);
    localparam logic [FW-1:0] FL_VM1 = FW'(FL - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WASH     = 3'd1,
        S_WASH_EXP = 3'd2,
        S_SPIN     = 3'd3,
        S_SPIN_EXP = 3'd4
    } state_t;

    state_t           state, state_nx;
    logic [PW-1:0]    pcnt, pcnt_nx;
    logic [CNT_W-1:0] rem, rem_nx;
    logic [CNT_W-1:0] wash_dur;
    logic             keep;

    logic             timeout_nx, spin_timeout_nx, busy_nx;
    logic [2:0]       phase_nx;
    logic [CNT_W-1:0] remaining_nx;

    // ---------------- state + output registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            pcnt         <= '0;
            rem          <= '0;
            timeout      <= 1'b0;
            spin_timeout <= 1'b0;
            busy         <= 1'b0;
            phase        <= 3'd0;
            remaining    <= '0;
        end else begin
            state        <= state_nx;
            pcnt         <= pcnt_nx;
            rem          <= rem_nx;
            timeout      <= timeout_nx;
            spin_timeout <= spin_timeout_nx;
            busy         <= busy_nx;
            phase        <= phase_nx;
            remaining    <= remaining_nx;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nx = state;
        pcnt_nx  = pcnt;
        rem_nx   = rem;
        keep     = 1'b0;

        case (prog)
            2'b00:   wash_dur = D_QUICK;
            2'b10:   wash_dur = D_HEAVY;
            default: wash_dur = D_NORMAL;
        endcase

        case (state)
            S_IDLE: begin
                // motor_on has priority when both requests arrive together
                if (motor_on) begin
                    state_nx = S_WASH;
                    rem_nx   = wash_dur;
                    pcnt_nx  = '0;
                end else if (drain_on) begin
                    state_nx = S_SPIN;
                    rem_nx   = D_SPIN;
                    pcnt_nx  = '0;
                end
            end
            S_WASH, S_SPIN: begin
                keep = (state == S_WASH) ? motor_on : drain_on;
                if (!keep) begin
                    // abort: back to IDLE without raising a timeout
                    state_nx = S_IDLE;
                    rem_nx   = '0;
                    pcnt_nx  = '0;
                end else if (!pause) begin
                    if (pcnt == PMAX) begin
                        pcnt_nx = '0;
                        if (rem != '0)
                            rem_nx = rem - 1'b1;
                        if (rem <= CNT_W'(1))
                            state_nx = (state == S_WASH) ? S_WASH_EXP : S_SPIN_EXP;
                    end else begin
                        pcnt_nx = pcnt + 1'b1;
                    end
                end
            end
            S_WASH_EXP: begin
                if (!motor_on) begin
                    state_nx = S_IDLE;
                    pcnt_nx  = '0;
                end
            end
            S_SPIN_EXP: begin
                if (!drain_on) begin
                    state_nx = S_IDLE;
                    pcnt_nx  = '0;
                end
            end
            default: begin
                state_nx = S_IDLE;
                rem_nx   = '0;
                pcnt_nx  = '0;
            end
        endcase
    end

    // ---------------- output decode (from next state) ----------------
    always_comb begin
        timeout_nx      = (state_nx == S_WASH_EXP);
        spin_timeout_nx = (state_nx == S_SPIN_EXP);
        busy_nx         = (state_nx != S_IDLE);
        phase_nx        = state_nx;
        remaining_nx    = ((state_nx == S_WASH) || (state_nx == S_SPIN)) ? rem_nx : '0;
    end

    // ---------------- fill watchdog ----------------
    // Runs regardless of FSM state and pause. The tick count saturates at the
    // limit, so while fill_on stays high the fault keeps re-asserting and
    // overrides clear_fault.
    logic [PW-1:0] fpcnt;
    logic [FW-1:0] ftick;
    logic          fset;

    assign fset = fill_on && ((ftick == FL_V) || ((fpcnt == PMAX) && (ftick == FL_VM1)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpcnt      <= '0;
            ftick      <= '0;
            fill_fault <= 1'b0;
        end else begin
            if (!fill_on) begin
                fpcnt <= '0;
                ftick <= '0;
            end else if (fpcnt == PMAX) begin
                fpcnt <= '0;
                if (ftick != FL_V)
                    ftick <= ftick + 1'b1;
            end else begin
                fpcnt <= fpcnt + 1'b1;
            end

            if (fset)
                fill_fault <= 1'b1;
            else if (clear_fault)
                fill_fault <= 1'b0;
        end
    end

endmodule
